// File: rtl/alu_mul_sequencer_if.sv
// Command/result and ALU-drive signal bundle for alu_mul_sequencer.
// slave = sequencer side, master = issue logic plus ALU side.
interface alu_mul_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_sub;
  logic [31:0] alu_sum;
  logic        alu_cout;

  modport slave (
    input  start, op, opa, opb, alu_sum, alu_cout,
    output busy, done, res_hi, res_lo,
    output alu_a, alu_b, alu_cin, alu_op1, alu_op2, alu_sub
  );

  modport master (
    output start, op, opa, opb, alu_sum, alu_cout,
    input  busy, done, res_hi, res_lo,
    input  alu_a, alu_b, alu_cin, alu_op1, alu_op2, alu_sub
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32->64 multiplier sequencing an external ripple ALU.
// Define ALU_SEQ_DIV_EN to add unsigned 32/32 restoring division (op=1).
module alu_mul_sequencer #(
  parameter int unsigned SETTLE = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_mul_sequencer_if.slave seq
);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] m;
  logic [5:0]  iter;
  logic [7:0]  settle;
  logic        capture;
  logic        last;
  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;

`ifdef ALU_SEQ_DIV_EN
  logic        div_mode;
  logic [31:0] p;
  logic        t;

  assign p = {hi[30:0], lo[31]};
  assign t = hi[31];
`else
  logic unused_op;
  assign unused_op = seq.op;
`endif

  // Capture at the edge ending the SETTLE-th cycle of each iteration.
  assign capture = (state == CALC) && (settle == SETTLE_LAST);
  assign last    = capture && (iter == 6'd31);

  assign seq.busy = (state == LOAD) || (state == CALC);
  assign seq.done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (seq.start) state_nxt = LOAD;
      LOAD:    state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs derive only from registers, so they move solely on capture edges.
  always_comb begin
    seq.alu_a   = '0;
    seq.alu_b   = '0;
    seq.alu_cin = 1'b0;
    seq.alu_op1 = '0;
    seq.alu_op2 = '0;
    seq.alu_sub = '0;
    hi_nxt      = hi;
    lo_nxt      = lo;
    if (state == CALC) begin
      seq.alu_op1 = '1;
`ifdef ALU_SEQ_DIV_EN
      if (div_mode) begin
        seq.alu_a   = p;
        seq.alu_b   = m;
        seq.alu_sub = '1;
        seq.alu_cin = 1'b1;
        if (t | seq.alu_cout) begin
          hi_nxt = seq.alu_sum;
          lo_nxt = {lo[30:0], 1'b1};
        end else begin
          hi_nxt = p;
          lo_nxt = {lo[30:0], 1'b0};
        end
      end else
`endif
      begin
        seq.alu_a = hi;
        seq.alu_b = m;
        if (lo[0]) {hi_nxt, lo_nxt} = {seq.alu_cout, seq.alu_sum, lo[31:1]};
        else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[31:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi         <= '0;
      lo         <= '0;
      m          <= '0;
      iter       <= '0;
      settle     <= '0;
      seq.res_hi <= '0;
      seq.res_lo <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_mode   <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          hi     <= '0;
          iter   <= '0;
          settle <= '0;
`ifdef ALU_SEQ_DIV_EN
          div_mode <= seq.op;
          lo       <= seq.op ? seq.opa : seq.opb;
          m        <= seq.op ? seq.opb : seq.opa;
`else
          lo       <= seq.opb;
          m        <= seq.opa;
`endif
        end
        CALC: begin
          if (capture) begin
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            settle <= '0;
            iter   <= iter + 6'd1;
            if (last) begin
              seq.res_hi <= hi_nxt;
              seq.res_lo <= lo_nxt;
            end
          end else begin
            settle <= settle + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
